// File: rtl/uart_rx_frame_if.sv
// Receive-side bundle: serial line in, parallel word and status strobes out.
// master = line driver / word consumer, slave = the receiver itself.
interface uart_rx_frame_if #(
    parameter int WORD_LENGTH = 8
) ();
    logic                   rx;
    logic [WORD_LENGTH-1:0] data_out;
    logic                   data_valid;
    logic                   parity_err;
    logic                   frame_err;
    logic                   busy;

    modport master (
        output rx,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  rx,
        output data_out, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling baud counter and a
// frame FSM that emits one-cycle word / framing-error strobes.
module uart_rx_frame #(
    parameter int    CLK_FREQ    = 50_000_000,
    parameter int    BAUD_RATE   = 115200,
    parameter int    WORD_LENGTH = 8,
    parameter int    STOP_BITS   = 2,
    parameter string PARITY      = "NONE"
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_frame_if.slave bus
);
    localparam int               BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int               CNT_W   = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(BIT_CYC / 2);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BIT_CYC - 1);
    localparam bit               HAS_PAR = (PARITY != "NONE");
    localparam bit               ODD_PAR = (PARITY == "ODD");

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t                 r_state, w_next;
    logic [1:0]             r_sync;
    logic                   r_rx_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [3:0]             r_bit;
    logic [WORD_LENGTH-1:0] r_shift, r_data;
    logic                   r_par_l, r_valid, r_perr, r_ferr;
    logic                   w_rx_s, w_fall, w_tick, w_last_data, w_last_stop;

    assign w_rx_s      = r_sync[1];
    assign w_fall      = r_rx_prev & ~w_rx_s;
    // First sample lands mid start bit; the counter then restarts so every later sample is one bit apart.
    assign w_tick      = (r_state == S_START) ? (r_cnt == HALF_C) : (r_cnt == LAST_C);
    assign w_last_data = (r_bit == 4'(WORD_LENGTH - 1));
    assign w_last_stop = (r_bit == 4'(STOP_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], bus.rx};
            r_rx_prev <= w_rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_next = S_START;
            S_START:  if (w_tick) w_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_tick && w_last_data) w_next = HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (w_tick) w_next = S_STOP;
            S_STOP: begin
                if (w_tick) begin
                    if (!w_rx_s)         w_next = S_BREAK;
                    else if (w_last_stop) w_next = S_IDLE;
                end
            end
            S_BREAK:  if (w_rx_s) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par_l <= 1'b0;
        end else begin
            if (r_state == S_IDLE || r_state == S_BREAK || w_tick) r_cnt <= '0;
            else                                                    r_cnt <= r_cnt + 1'b1;

            if (r_state == S_IDLE) r_bit <= '0;
            else if (w_tick) begin
                if ((r_state == S_DATA && !w_last_data) || r_state == S_STOP) r_bit <= r_bit + 4'd1;
                else                                                           r_bit <= '0;
            end

            if (r_state == S_DATA && w_tick) r_shift <= {w_rx_s, r_shift[WORD_LENGTH-1:1]};

            if (r_state == S_IDLE)                             r_par_l <= 1'b0;
            else if (HAS_PAR && r_state == S_PARITY && w_tick) r_par_l <= w_rx_s ^ (^r_shift) ^ ODD_PAR;
        end
    end

    // Strobes are registered, so they appear the cycle after the deciding stop sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            if (r_state == S_STOP && w_tick) begin
                if (!w_rx_s) r_ferr <= 1'b1;
                else if (w_last_stop) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                    r_perr  <= r_par_l;
                end
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive front end that deserialises the board-level `rx` line into parallel words for the command/LED logic behind it.
- Directly upstream of the LED control datapath in the top-level UART design; its outputs drive that logic's word/strobe inputs.
- Frame format is fixed at elaboration: 1 start bit, WORD_LENGTH data bits LSB first, optional parity bit, STOP_BITS stop bits.
- Sampling is at mid-bit using a baud counter derived from CLK_FREQ/BAUD_RATE.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s. The bit period is BIT_CYC = CLK_FREQ/BAUD_RATE, integer-truncated (434 at the defaults).
- WORD_LENGTH, 8, data bits per frame. Legal range 5..9.
- STOP_BITS, 2, stop bits per frame. Legal values 1 or 2.
- PARITY, "NONE", one of "NONE", "EVEN" or "ODD".

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high; asynchronous to clk.
- data_out  output  WORD_LENGTH  last received word, bit 0 = first data bit on the line.
- data_valid  output  1  one-cycle strobe; data_out is valid in the same cycle.
- parity_err  output  1  qualifies data_valid; 1 = parity mismatch. Always 0 when PARITY="NONE".
- frame_err  output  1  one-cycle strobe; a stop bit was sampled low.
- busy  output  1  high from start-bit detection until the block returns to IDLE.

Behaviour:
- Clock and reset: one clock (`clk`). Reset (`rst`) is asynchronous and active-high.
- Reset state: FSM=IDLE; counters cleared; synchroniser flops = 1. Outputs: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
- Reset mid-frame aborts the frame with no strobe.
- Synchroniser: rx passes through 2 flops (rx_s). Only rx_s is used downstream. This adds 2 cycles of latency on edge detection.
- Baud counter:
  - Counts 0..BIT_CYC-1.
  - Reloaded to 0 on start-bit detection and at every bit boundary.
  - A sample point occurs at count == BIT_CYC/2 (217) for the start bit, then every BIT_CYC cycles thereafter.
- FSM states:
  - IDLE: busy=0. A falling edge on rx_s (prev 1, now 0) enters START and sets busy=1.
  - START: at the half-bit sample, rx_s=0 → DATA. rx_s=1 → false start: back to IDLE, busy=0, no strobe.
  - DATA: WORD_LENGTH samples, shifted in LSB first. After the last sample go to PARITY if PARITY≠"NONE", otherwise to STOP.
  - PARITY: one sample. Expected bit = XOR of data for EVEN, inverted XOR for ODD. The mismatch is latched.
  - STOP: STOP_BITS samples.
    - All samples high: on the cycle after the final stop sample, data_out is updated, data_valid=1 for 1 cycle, parity_err=latched mismatch for that cycle, then IDLE.
    - Any stop sample low: abort immediately. frame_err=1 for 1 cycle; data_out is unchanged; data_valid stays 0. Go to BREAK.
  - BREAK: busy=1. Wait until rx_s=1, then IDLE. Prevents a held-low line from restarting frames.
- Back-to-back frames: the FSM returns to IDLE at the middle of the last stop bit, so a start edge immediately following the stop bit is caught. No inter-frame gap is required.
- data_out holds its value between strobes. parity_err is 0 whenever data_valid=0.
- There is no ready/backpressure. The consumer must accept the word on the strobe cycle; a new frame overwrites data_out.
- A glitch low shorter than BIT_CYC/2 cycles is rejected via the START check.

Test Plan:
- Defaults, rx sends 0xFA as 8N2 with an 8680 ns bit time → exactly one data_valid pulse, data_out=0xFA, parity_err=0, frame_err=0, busy low afterwards.
- Continuous back-to-back frames 0xFA, 0xFF, 0xA5 with no gap → three data_valid pulses in order with values FA, FF, A5, spaced 11×434 cycles apart.
- rx low pulse of 2 µs (100 cycles) in IDLE → no data_valid, no frame_err, busy returns to 0 at about cycle 219.
- Frame 0x55 with the first stop bit driven low, then rx held low for 3 bit times and released → one frame_err pulse, no data_valid, data_out unchanged, busy stays 1 until rx rises.
- PARITY="EVEN": send 0x03 with parity bit 1 → data_valid with parity_err=1, data_out=0x03. Resend with parity bit 0 → parity_err=0.
- Assert rst during DATA of 0xA5, release, then send 0x3C → no strobe for the aborted frame; outputs are 0 during reset; next word data_out=0x3C.
